// File: rtl/hgcal_fc_l1a_monitor_if.sv
// Timestamp readout stream of the fast-control L1A monitor.
// FWFT: head entry is valid while ts_valid=1, popped by ts_ready.
interface hgcal_fc_l1a_monitor_if;
    logic        ts_valid;
    logic        ts_ready;
    logic [11:0] ts_bx;
    logic [19:0] ts_orbit;

    modport master (
        output ts_valid, ts_bx, ts_orbit,
        input  ts_ready
    );
    modport slave (
        input  ts_valid, ts_bx, ts_orbit,
        output ts_ready
    );
endinterface

// File: rtl/hgcal_fc_l1a_monitor.sv
// Fast-control L1A monitor: BX/orbit tracking from BCR, L1A timestamp FIFO.
// Optional periodic L1A check via HGCAL_FC_L1A_PERIOD_CHECK_EN.
module hgcal_fc_l1a_monitor #(
    parameter int BX_PER_ORBIT = 3564,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk40,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        l1a,
    input  logic        bcr,
    input  logic        clear_counters,
    input  logic [11:0] expected_bx,
    input  logic [19:0] expected_prescale,
    output logic [11:0] bx_now,
    output logic [19:0] orbit_count,
    output logic        locked,
    hgcal_fc_l1a_monitor_if.master ts,
    output logic [15:0] overflow_count,
    output logic [15:0] bcr_err_count,
    output logic [15:0] period_err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [11:0] LAST_BX = 12'(BX_PER_ORBIT - 1);

    logic [11:0] bx_q, bx_d;
    logic [19:0] orbit_q, orbit_d;
    logic        locked_q, locked_d;
    logic [AW:0] wr_q, rd_q;
    logic [15:0] ovf_q, berr_q;
    logic [31:0] mem [FIFO_DEPTH];
    logic [31:0] head;
    logic        aligned, wrap, empty, full;
    logic        armed, push, pop;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        aligned  = (bx_q == LAST_BX);
        wrap     = bcr || aligned;
        bx_d     = wrap ? 12'd0 : bx_q + 12'd1;
        orbit_d  = wrap ? orbit_q + 20'd1 : orbit_q;
        locked_d = bcr ? aligned : locked_q;
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW-1:0] == rd_q[AW-1:0])
                && (wr_q[AW] != rd_q[AW]);
        armed    = l1a && enable && locked_q;
        push     = armed && !full;
        pop      = !empty && ts.ts_ready;
        head     = mem[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            bx_q     <= '0;
            orbit_q  <= '0;
            locked_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            ovf_q    <= '0;
            berr_q   <= '0;
        end else begin
            bx_q     <= bx_d;
            orbit_q  <= orbit_d;
            locked_q <= locked_d;
            wr_q     <= wr_q + {{AW{1'b0}}, push};
            rd_q     <= rd_q + {{AW{1'b0}}, pop};
            if (clear_counters) begin
                ovf_q  <= '0;
                berr_q <= '0;
            end else begin
                if (armed && full)
                    ovf_q <= sat16(ovf_q);
                if (bcr && locked_q && !aligned)
                    berr_q <= sat16(berr_q);
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk40) begin
        if (push)
            mem[wr_q[AW-1:0]] <= {bx_q, orbit_q};
    end

`ifdef HGCAL_FC_L1A_PERIOD_CHECK_EN
    logic        ref_v_q;
    logic [19:0] ref_orb_q;
    logic [15:0] perr_q;
    logic        period_bad;

    always_comb begin
        period_bad = (bx_q != expected_bx)
                  || (ref_v_q && ((orbit_q - ref_orb_q)
                                  != (expected_prescale + 20'd1)));
    end

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            ref_v_q   <= 1'b0;
            ref_orb_q <= '0;
            perr_q    <= '0;
        end else begin
            if (clear_counters)
                perr_q <= '0;
            else if (push && period_bad)
                perr_q <= sat16(perr_q);
            if (clear_counters || (locked_q && !locked_d)) begin
                ref_v_q <= 1'b0;
            end else if (push) begin
                ref_v_q   <= 1'b1;
                ref_orb_q <= orbit_q;
            end
        end
    end

    assign period_err_count = perr_q;
`else
    logic unused_period_cfg;
    assign unused_period_cfg = ^{expected_bx, expected_prescale};
    assign period_err_count  = '0;
`endif

    assign bx_now         = bx_q;
    assign orbit_count    = orbit_q;
    assign locked         = locked_q;
    assign overflow_count = ovf_q;
    assign bcr_err_count  = berr_q;
    assign ts.ts_valid    = !empty;
    assign ts.ts_bx       = empty ? 12'd0 : head[31:20];
    assign ts.ts_orbit    = empty ? 20'd0 : head[19:0];

endmodule

// File: doc/hgcal_fc_l1a_monitor.md
# hgcal_fc_l1a_monitor

Receive-side fast-control monitor for the front end. It consumes decoded fast commands (one-cycle `l1a` and `bcr` strobes) and reconstructs the local bunch-crossing and orbit count from `bcr`. Each accepted L1A is timestamped and buffered for readout. Optionally, the block checks that L1As match the periodic pattern the fast-control manager was configured to produce (target BX and orbit prescale).

## Interface
Parameters:
- `BX_PER_ORBIT`, 3564: BX counter modulus.
- `FIFO_DEPTH`, 8: timestamp FIFO depth; power of two, at least 2.

Ports:
- `clk40` in 1: 40 MHz fast-control clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, L1As are ignored; BX/orbit tracking continues.
- `l1a` in 1: decoded L1A strobe, one cycle.
- `bcr` in 1: decoded bunch-count-reset strobe, one cycle.
- `clear_counters` in 1: synchronous clear of the error counters and of the period-check reference.
- `expected_bx` in 12: BX at which periodic L1As must land.
- `expected_prescale` in 20: orbits between periodic L1As, minus 1.
- `bx_now` out 12: local BX count.
- `orbit_count` out 20: local orbit count, wraps.
- `locked` out 1: BX counter aligned to `bcr`.
- `ts_valid` out 1: FIFO not empty.
- `ts_bx` out 12: BX of the head timestamp.
- `ts_orbit` out 20: orbit of the head timestamp.
- `ts_ready` in 1: consumer pop request.
- `overflow_count` out 16: L1As dropped because the FIFO was full.
- `bcr_err_count` out 16: misaligned `bcr` received while locked.
- `period_err_count` out 16: periodic-check mismatches.

## Operation
Reset values:
- All outputs are 0.
- FIFO is empty.
- Period-check reference is invalid.

BX and orbit tracking:
- `bx_now` increments every cycle and wraps from `BX_PER_ORBIT`-1 to 0.
- A `bcr` in cycle t forces `bx_now`=0 in cycle t+1.
- `orbit_count` increments on every transition of `bx_now` to 0, whether it is a natural wrap or forced by `bcr`.

Lock:
- A `bcr` with `bx_now`==`BX_PER_ORBIT`-1 sets `locked`.
- A `bcr` with any other `bx_now` clears `locked`.
- A misaligned `bcr` while `locked`=1 also increments `bcr_err_count`.
- The first `bcr` after reset only aligns the counter; it never counts as an error.

L1A capture:
- An L1A is accepted when `l1a`, `enable` and `locked` are all 1 and the FIFO is not full. The accepted entry is {`bx_now`, `orbit_count`} as sampled in the `l1a` cycle.
- `l1a` with the FIFO full increments `overflow_count`. The entry is dropped.
- A push while full is rejected even if a pop occurs in the same cycle.
- `l1a` while unlocked or disabled is discarded without counting.

FIFO:
- First-word-fall-through: `ts_bx`/`ts_orbit` present the head entry while `ts_valid`=1.
- Pop happens on `ts_valid` && `ts_ready`.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy constant.

Counters:
- All three error counters are 16-bit and saturate at 16'hFFFF.
- `clear_counters` wins over an increment in the same cycle.
- `locked` falling, or `clear_counters`, invalidates the period reference.

## Timing
- `l1a` accepted at edge t gives `ts_valid`=1 after edge t, i.e. visible in cycle t+1. No added latency when the FIFO is non-empty.
- A pop at edge t advances the head in cycle t+1; `ts_valid` drops in t+1 if the FIFO is then empty.
- Counter, `locked` and `bx_now` updates are registered: one cycle after the causing strobe.
- `reset_n` asserted mid-operation immediately flushes the FIFO and returns every output to its reset value.
- `bcr` and `l1a` in the same cycle: the L1A is stamped with the pre-reset `bx_now`.

## Configuration
`HGCAL_FC_L1A_PERIOD_CHECK_EN`:
- Defined: the periodic check is compiled in and runs on every accepted L1A.
  - The check fails, and `period_err_count` increments once, if `ts` BX != `expected_bx`, or if a valid reference exists and (orbit − reference orbit) mod 2^20 != `expected_prescale`+1.
  - The L1A then becomes the new reference.
  - The first accepted L1A after reset, lock loss or clear checks BX only.
- Undefined: no check logic is generated and `period_err_count` is tied to 0.

## Test plan
- Reset, then `bcr` every 3564 cycles → `locked`=1 after the second `bcr`; `bx_now` is 0 the cycle after each `bcr`; `bcr_err_count`=0.
- While locked, inject `bcr` at `bx_now`=100 → `locked`=0, `bcr_err_count`=1, `bx_now`=0 next cycle; the next aligned `bcr` relocks.
- With `ts_ready`=0, send 10 L1As → 8 entries held, `overflow_count`=2. Then raise `ts_ready` → 8 pops in order with the correct bx/orbit values, and `ts_valid` falls after the last pop.
- Check enabled, `expected_bx`=40, `expected_prescale`=3, L1As at BX 40 every 4 orbits → `period_err_count`=0. One L1A at BX 41 → 1. Skipping one period → 2.
- `l1a` with `enable`=0 or while unlocked → FIFO unchanged, no counter moves.
- Assert `reset_n` low mid-burst with the FIFO holding 3 entries → `ts_valid`=0 and all counters 0 immediately.
